// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles big-endian 32-bit words from a byte
// stream, writes them through a one-cycle port, and verifies a trailing XOR checksum.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   word_count,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CSUM, FIN} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [31:0]   asm_q, asm_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [AW:0]   widx_q, widx_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          err_q, err_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          xfer;
    logic [31:0]   asm_next;
    logic [AW:0]   widx_inc;

    // Outputs decode from the state register only, so no input reaches an output combinationally.
    assign byte_ready = (state_q == LOAD) || (state_q == CSUM);
    assign mem_we     = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign error      = err_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;

    assign xfer     = byte_valid && byte_ready;
    assign asm_next = {asm_q[23:0], byte_data};
    assign widx_inc = widx_q + {{AW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (start) begin
                err_d  = 1'b0;
                acc_d  = '0;
                bcnt_d = '0;
                widx_d = '0;
                wcnt_d = word_count;
                if (word_count > DEPTH_W) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (word_count == '0) begin
                    state_d = CSUM;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: if (xfer) begin
                asm_d  = asm_next;
                bcnt_d = bcnt_q + 2'd1;
                // Write port registers are loaded here so they hold steady outside WRITE.
                if (bcnt_q == 2'd3) begin
                    waddr_d = widx_q[AW-1:0];
                    wdata_d = asm_next;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d   = acc_q ^ wdata_q;
                widx_d  = widx_inc;
                state_d = (widx_inc == wcnt_q) ? CSUM : LOAD;
            end
            CSUM: if (xfer) begin
                asm_d  = asm_next;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    err_d   = (asm_next != acc_q);
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            asm_q   <= '0;
            bcnt_q  <= '0;
            widx_q  <= '0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            widx_q  <= widx_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, gaps, bounds, mid-load reset, start while busy.
module tb_imem_loader;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, mem_we, busy, done, error;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          rnd_gaps = 1'b0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [31:0]   wbuf[0:15];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every memory write and checks the handshake is closed meanwhile.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_waddr);
            wd.push_back(mem_wdata);
            chk("ready_in_write", byte_ready, 1'b0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (rnd_gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic load(input int wc, input int nw, input logic [31:0] csum,
                        input bit send_csum, input bit pulse_start, output logic err_o);
        int t = 0;
        wa.delete();
        wd.delete();
        start      = 1'b1;
        word_count = (AW+1)'(wc);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", byte_ready, (wc <= DEPTH) ? 1'b1 : 1'b0);
        if (wc > DEPTH) chk("oversize_done_next", done, 1'b1);
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(wbuf[i][31-8*j -: 8]);
                if (pulse_start && i == 0 && j == 0) begin
                    start      = 1'b1;
                    word_count = 5'd1;
                end
                if (pulse_start && i == 0 && j == 1) start = 1'b0;
            end
        end
        if (send_csum)
            for (int j = 0; j < 4; j++) send_byte(csum[31-8*j -: 8]);
        byte_valid = 1'b0;
        while (done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done", done, 1'b1);
        err_o = error;
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic check_writes(input int nw);
        chk("wr_count", wa.size(), nw);
        for (int i = 0; i < nw && i < wa.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), wa[i], i);
            chk($sformatf("wr_data%0d", i), wd[i], wbuf[i]);
        end
    endtask

    task automatic set_nominal();
        wbuf[0] = 32'h00221820;
        wbuf[1] = 32'h2109000A;
    endtask

    initial begin
        logic        e;
        logic [31:0] cs;
        repeat (2) @(negedge clk);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        set_nominal();
        load(2, 2, 32'h212B182A, 1'b1, 1'b0, e);
        chk("nominal_err", e, 1'b0);
        check_writes(2);

        load(2, 2, 32'h00000000, 1'b1, 1'b0, e);
        chk("badcs_err", e, 1'b1);
        check_writes(2);
        repeat (3) @(negedge clk);
        chk("badcs_sticky", error, 1'b1);

        rnd_gaps = 1'b1;
        load(2, 2, 32'h212B182A, 1'b1, 1'b0, e);
        rnd_gaps = 1'b0;
        chk("gaps_err", e, 1'b0);
        check_writes(2);

        load(17, 0, 32'h0, 1'b0, 1'b0, e);
        chk("oversize_err", e, 1'b1);
        check_writes(0);

        load(0, 0, 32'h0, 1'b1, 1'b0, e);
        chk("zero_err", e, 1'b0);
        check_writes(0);

        cs = 32'h0;
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = 32'hA5000000 ^ (i * 32'h01020304);
            cs ^= wbuf[i];
        end
        load(16, 16, cs, 1'b1, 1'b0, e);
        chk("full_err", e, 1'b0);
        check_writes(16);

        set_nominal();
        wa.delete();
        wd.delete();
        start      = 1'b1;
        word_count = 5'd2;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00);
        send_byte(8'h22);
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", byte_ready, 1'b0);
        chk("midrst_we", mem_we, 1'b0);
        chk("midrst_waddr", mem_waddr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_error", error, 1'b0);
        chk("midrst_nowr", wa.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(2, 2, 32'h212B182A, 1'b1, 1'b0, e);
        chk("after_rst_err", e, 1'b0);
        check_writes(2);

        load(2, 2, 32'h212B182A, 1'b1, 1'b1, e);
        chk("start_busy_err", e, 1'b0);
        check_writes(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory through a one-cycle write port, and a trailing XOR checksum is verified at the end. While loading, it holds the CPU in reset, acting as the writer side of the instruction memory that the fetch path only reads.

## Interface
Parameters:
- DEPTH, 16, number of instruction words in the instruction memory.
- AW, 4, word-address width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  in  AW+1  number of instruction words to load; latched when start is accepted.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready at a rising edge.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  out  AW  word index to write (word addressing, index 0 = first instruction).
- mem_wdata  out  32  instruction word to write.
- busy  out  1  load in progress; drives the CPU hold/reset.
- done  out  1  one-cycle pulse at the end of every accepted load, including error cases.
- error  out  1  sticky result flag; cleared when the next start is accepted.

## Operation
- FSM states: IDLE, LOAD, WRITE, CSUM, FIN.
- IDLE:
  - byte_ready=0, busy=0.
  - On start:
    - clear error, the XOR accumulator, the byte counter and the word index; latch word_count.
    - word_count > DEPTH -> FIN with error pending.
    - word_count == 0 -> CSUM.
    - otherwise -> LOAD.
- LOAD: byte_ready=1. Each accepted byte shifts into the assembly register big-endian: the 1st byte goes to [31:24] and the 4th byte to [7:0]. Acceptance of the 4th byte -> WRITE.
- WRITE:
  - byte_ready=0.
  - mem_we=1 for exactly one cycle, with mem_waddr=word index and mem_wdata=assembled word.
  - The accumulator XORs in the word and the word index increments.
  - Next state: if the index equals word_count -> CSUM, else LOAD.
- CSUM: byte_ready=1. Assemble 4 more bytes, big-endian. After the 4th byte -> FIN; error is set if the received word != accumulator.
- FIN: done=1 for one cycle, busy still 1; -> IDLE. The error value is valid from the done cycle and holds until the next accepted start.
- start outside IDLE is ignored. byte_valid in IDLE, WRITE or FIN is not consumed.
- mem_waddr and mem_wdata hold their last written values when mem_we=0.
- Word index arithmetic is AW+1 bits wide, so word_count == DEPTH == 2**AW is legal with no wrap.
- The loader never writes beyond index word_count-1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE and the partial word is discarded.
  - byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, error=0.
  - Reset mid-load issues no further writes; already-written words remain in memory.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- start accepted at edge E -> busy=1 and byte_ready=1 from E (the LOAD/CSUM case).
- 4th data byte accepted at edge N:
  - mem_we=1 in the cycle between edges N and N+1, and memory captures at N+1.
  - byte_ready is low in that cycle and returns high after N+1.
- Minimum load time with byte_valid held high: 5 cycles per word + 4 checksum cycles + 1 FIN cycle.
- Oversize word_count: done=1 and error=1 in the cycle after the start edge; no bytes accepted, no mem_we.
- Gaps in byte_valid stall assembly indefinitely; there is no timeout.

## Test plan
- Nominal load: word_count=2, with byte_valid held high.
  - Stream 00 22 18 20, 21 09 00 0A, 21 2B 18 2A.
  - Expect mem_we at index 0 with 0x00221820, and at index 1 with 0x2109000A.
  - Then done=1, error=0, busy falls after done.
- Bad checksum: the same two words followed by checksum 00 00 00 00.
  - Both writes still occur; done=1 with error=1.
  - error stays 1 until the next start.
- Backpressure/gaps: the nominal stream with byte_valid toggling randomly, including valid held high through WRITE.
  - Identical writes occur, and no byte is lost or duplicated.
  - byte_ready=0 in every mem_we cycle.
- Bounds: word_count=17 -> done and error=1 the next cycle, and zero mem_we.
  - word_count=16 with 64 bytes + correct checksum -> writes at indices 0..15, error=0.
  - word_count=0 with checksum 00 00 00 00 -> done, error=0, no writes.
- Reset mid-load: assert rst_n=0 after 2 bytes of word 0.
  - All outputs go to 0 immediately, with no mem_we.
  - A fresh nominal load then succeeds from index 0.
- start while busy: pulse start during LOAD. The load is unaffected and word_count is not re-latched.
